reg_bank_sequencer: RTL

- Initiator side of the 8x8 register bank: accepts register-level commands over a valid/ready handshake and drives the bank's read-address, write-address, write-data and write-enable ports.
- Performs one 8-bit ALU operation per command on bank operands and writes the result back.
- Returns the result and flags on a response handshake.
- Sits between the instruction control path (or a test/debug master) and the register bank; matches the bank's timing: writes commit on the posedge, read data updates on the negedge.

---
 rtl/reg_bank_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/reg_bank_sequencer.sv
// Command sequencer for the 8x8 register bank: reads operands, runs one ALU op,
// writes the result back and returns it on a response handshake.
//
// Handshakes: a transfer happens on a posedge where valid && ready are both high.
// Valid and the payload it qualifies stay stable until that edge.
module reg_bank_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic [2:0]        CmdOp,
    input  logic [ADDR_W-1:0] CmdRd,
    input  logic [ADDR_W-1:0] CmdRs1,
    input  logic [ADDR_W-1:0] CmdRs2,
    input  logic [DATA_W-1:0] CmdImm,
    output logic [ADDR_W-1:0] RegLido1,
    output logic [ADDR_W-1:0] RegLido2,
    input  logic [DATA_W-1:0] Dado1,
    input  logic [DATA_W-1:0] Dado2,
    output logic [ADDR_W-1:0] RegEscr,
    output logic [DATA_W-1:0] DadoEscr,
    output logic              RegWrite,
    output logic              RespValid,
    input  logic              RespReady,
    output logic [DATA_W-1:0] RespData,
    output logic              RespZero,
    output logic              RespCarry,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_LI   = 3'b101;
    localparam logic [2:0] OP_READ = 3'b110;
    localparam logic [2:0] OP_ADDI = 3'b111;

    state_t              state, state_nx;
    logic [2:0]          op_q, op_nx;
    logic [ADDR_W-1:0]   rd_q, rd_nx;
    logic [DATA_W-1:0]   imm_q, imm_nx;
    logic                carry_q, carry_nx;
    logic [ADDR_W-1:0]   lido1_nx, lido2_nx, escr_nx;
    logic [DATA_W-1:0]   dado_escr_nx, resp_data_nx;
    logic                write_nx, resp_valid_nx, resp_zero_nx, resp_carry_nx;
    logic [DATA_W:0]     alu;

    assign CmdReady  = (state == IDLE) && !Reset;
    assign state_dbg = state;

    // Top bit is carry for the adds and borrow for SUB (a - b wraps when a < b).
    always_comb begin
        alu = '0;
        case (op_q)
            OP_ADD:  alu = {1'b0, Dado1} + {1'b0, Dado2};
            OP_SUB:  alu = {1'b0, Dado1} - {1'b0, Dado2};
            OP_AND:  alu = {1'b0, Dado1 & Dado2};
            OP_OR:   alu = {1'b0, Dado1 | Dado2};
            OP_XOR:  alu = {1'b0, Dado1 ^ Dado2};
            OP_ADDI: alu = {1'b0, Dado1} + {1'b0, imm_q};
            default: alu = {1'b0, Dado1};
        endcase
    end

    always_comb begin
        state_nx      = state;
        op_nx         = op_q;
        rd_nx         = rd_q;
        imm_nx        = imm_q;
        carry_nx      = carry_q;
        lido1_nx      = RegLido1;
        lido2_nx      = RegLido2;
        escr_nx       = RegEscr;
        dado_escr_nx  = DadoEscr;
        write_nx      = RegWrite;
        resp_valid_nx = RespValid;
        resp_data_nx  = RespData;
        resp_zero_nx  = RespZero;
        resp_carry_nx = RespCarry;
        case (state)
            IDLE: begin
                if (CmdValid && CmdReady) begin
                    op_nx    = CmdOp;
                    rd_nx    = CmdRd;
                    imm_nx   = CmdImm;
                    lido1_nx = CmdRs1;
                    lido2_nx = CmdRs2;
                    if (CmdOp == OP_LI) begin
                        write_nx     = 1'b1;
                        escr_nx      = CmdRd;
                        dado_escr_nx = CmdImm;
                        carry_nx     = 1'b0;
                        state_nx     = WRITE;
                    end else begin
                        state_nx = READ;
                    end
                end
            end
            READ: begin
                // Dado1/Dado2 were refreshed by the bank at the negedge just passed.
                if (op_q == OP_READ) begin
                    resp_valid_nx = 1'b1;
                    resp_data_nx  = Dado1;
                    resp_zero_nx  = (Dado1 == '0);
                    resp_carry_nx = 1'b0;
                    state_nx      = RESP;
                end else begin
                    write_nx     = 1'b1;
                    escr_nx      = rd_q;
                    dado_escr_nx = alu[DATA_W-1:0];
                    carry_nx     = alu[DATA_W];
                    state_nx     = WRITE;
                end
            end
            WRITE: begin
                write_nx      = 1'b0;
                resp_valid_nx = 1'b1;
                resp_data_nx  = DadoEscr;
                resp_zero_nx  = (DadoEscr == '0);
                resp_carry_nx = carry_q;
                state_nx      = RESP;
            end
            RESP: begin
                if (RespReady) begin
                    resp_valid_nx = 1'b0;
                    state_nx      = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            carry_q   <= 1'b0;
            RegLido1  <= '0;
            RegLido2  <= '0;
            RegEscr   <= '0;
            DadoEscr  <= '0;
            RegWrite  <= 1'b0;
            RespValid <= 1'b0;
            RespData  <= '0;
            RespZero  <= 1'b0;
            RespCarry <= 1'b0;
        end else begin
            state     <= state_nx;
            op_q      <= op_nx;
            rd_q      <= rd_nx;
            imm_q     <= imm_nx;
            carry_q   <= carry_nx;
            RegLido1  <= lido1_nx;
            RegLido2  <= lido2_nx;
            RegEscr   <= escr_nx;
            DadoEscr  <= dado_escr_nx;
            RegWrite  <= write_nx;
            RespValid <= resp_valid_nx;
            RespData  <= resp_data_nx;
            RespZero  <= resp_zero_nx;
            RespCarry <= resp_carry_nx;
        end
    end

endmodule
